// File: rtl/brseq_pkg.sv
// Shared widths, flag-index names and the action encoding for the branch sequencer.
package brseq_pkg;

    localparam int COND_SEL_W = 3;
    localparam int OP_W       = COND_SEL_W + 1;
    localparam int FLAGS_W    = 2 ** COND_SEL_W;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_CARRY    = 1;
    localparam int FLAG_SIGN     = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_PARITY   = 4;

    typedef enum logic [1:0] {
        ACT_INC  = 2'd0,
        ACT_JMP  = 2'd1,
        ACT_CALL = 2'd2,
        ACT_RET  = 2'd3
    } action_e;

    // Return beats call beats jump; with no request the address increments.
    function automatic action_e select_action(input logic jmp, input logic call, input logic ret);
        action_e act;
        if (ret) begin
            act = ACT_RET;
        end else if (call) begin
            act = ACT_CALL;
        end else if (jmp) begin
            act = ACT_JMP;
        end else begin
            act = ACT_INC;
        end
        return act;
    endfunction

endpackage

// File: rtl/return_stack.sv
// DEPTH x AW LIFO holding call return addresses; push and pop are never issued together.
module return_stack
    import brseq_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [AW-1:0]   push_data,
    output logic [AW-1:0]   top,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   mem_d [DEPTH];
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic [IW-1:0]   push_idx_s;
    logic [IW-1:0]   top_idx_s;

    assign full       = (count_q == CNTW'(DEPTH));
    assign empty      = (count_q == {CNTW{1'b0}});
    assign count      = count_q;
    assign push_idx_s = count_q[IW-1:0];
    assign top_idx_s  = IW'(count_q - CNTW'(1));
    assign top        = mem_q[top_idx_s];

    // Next storage and occupancy.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[push_idx_s] = push_data;
            count_d           = count_q + CNTW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNTW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Entry storage; contents are meaningless above the occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNTW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Program counter with conditional jump and call/return through a hardware stack.
// Optional feature macro BRSEQ_RELATIVE_EN adds REL for PC-relative jump/call destinations.
module branch_sequencer
    import brseq_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = COND_SEL_W,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              JMP_INST,
    input  logic              CALL_INST,
    input  logic              RET_INST,
    input  logic [CW:0]       OP,
    input  logic [2**CW-1:0]  FLAGS,
    input  logic [AW-1:0]     TARGET,
`ifdef BRSEQ_RELATIVE_EN
    input  logic              REL,
`endif
    output logic [AW-1:0]     ADDR,
    output logic [SPW-1:0]    SP,
    output logic              TAKEN,
    output logic              OVF,
    output logic              UNF
);

    logic [AW-1:0] addr_q, addr_d;
    logic          taken_q, taken_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    action_e       act_s;
    logic          cond_s;
    logic [AW-1:0] inc_s;
    logic [AW-1:0] dest_s;
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] stk_top_s;
    logic          stk_full_s;
    logic          stk_empty_s;

    assign act_s  = select_action(JMP_INST, CALL_INST, RET_INST);
    assign cond_s = (FLAGS[OP[CW-1:0]] == OP[CW]);
    assign inc_s  = addr_q + AW'(1);
`ifdef BRSEQ_RELATIVE_EN
    // TARGET and ADDR share width, so modular addition already sign-extends the offset.
    assign dest_s = REL ? (addr_q + TARGET) : TARGET;
`else
    assign dest_s = TARGET;
`endif

    assign push_s = EN && (act_s == ACT_CALL) && !stk_full_s;
    assign pop_s  = EN && (act_s == ACT_RET) && !stk_empty_s;

    return_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .CNTW  (SPW)
    ) u_stack (
        .clk       (CLK),
        .rst       (RST),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (inc_s),
        .top       (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s),
        .count     (SP)
    );

    // Next-address mux and status flags.
    always_comb begin
        addr_d  = addr_q;
        taken_d = taken_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (EN) begin
            addr_d  = inc_s;
            taken_d = 1'b0;
            case (act_s)
                ACT_RET: begin
                    if (!stk_empty_s) begin
                        addr_d  = stk_top_s;
                        taken_d = 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                ACT_CALL: begin
                    if (!stk_full_s) begin
                        addr_d  = dest_s;
                        taken_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                ACT_JMP: begin
                    if (cond_s) begin
                        addr_d  = dest_s;
                        taken_d = 1'b1;
                    end else begin
                        taken_d = 1'b0;
                    end
                end
                ACT_INC: begin
                    addr_d = inc_s;
                end
                default: begin
                    addr_d = inc_s;
                end
            endcase
        end else begin
            addr_d = addr_q;
        end
    end

    // Address and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= {AW{1'b0}};
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ADDR  = addr_q;
    assign TAKEN = taken_q;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;

endmodule
